// File: rtl/flash_hps_bridge.sv
// Avalon-MM register bank turning HPS writes into timed change/schedule request pulses for the FLASH wrapper.
// Read latency 1; no backpressure: writes to a busy channel are discarded and flagged in STATUS.dropped.
module flash_hps_bridge #(
  parameter int REQ_HOLD  = 4,
  parameter int GUARD     = 8,
  parameter int SCHED_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic [47:0] hps_change_data,
  output logic        hps_change_req,
  output logic        hps_sched_req,
  input  logic [15:0] hps_next_process,
  input  logic        hps_tick_irq
);

  localparam logic [7:0] HOLD_M1  = 8'(REQ_HOLD - 1);
  localparam logic [7:0] GUARD_M1 = 8'(GUARD - 1);
  localparam logic [7:0] LAT_M1   = 8'(SCHED_LAT - 1);

  typedef enum logic [1:0] {C_IDLE, C_HOLD, C_GUARD} chg_st_t;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WAIT} sch_st_t;

  chg_st_t     r_chg_st, w_chg_nxt;
  sch_st_t     r_sch_st, w_sch_nxt;
  logic [7:0]  r_chg_cnt, w_chg_cnt_nxt;
  logic [7:0]  r_sch_cnt, w_sch_cnt_nxt;
  logic [7:0]  r_type, r_pri;
  logic [15:0] r_pid, r_state;
  logic [15:0] r_next;
  logic        r_next_vld;
  logic        r_tick_q;
  logic [31:0] r_ticks;
  logic        r_pend, r_ovr, r_drop, r_irq_en, r_irq;

  logic        w_wr_a, w_wr_b, w_wr_s, w_wr_ack, w_wr_ctrl, w_rd_next;
  logic        w_chg_busy, w_sch_busy, w_capture, w_tick_edge, w_drop_set;
  logic [31:0] w_rdata;

  assign w_wr_a    = avs_write && (avs_address == 3'd0);
  assign w_wr_b    = avs_write && (avs_address == 3'd1);
  assign w_wr_s    = avs_write && (avs_address == 3'd2);
  assign w_wr_ack  = avs_write && (avs_address == 3'd5);
  assign w_wr_ctrl = avs_write && (avs_address == 3'd7);
  assign w_rd_next = avs_read  && (avs_address == 3'd3);

  assign w_chg_busy  = (r_chg_st != C_IDLE);
  assign w_sch_busy  = (r_sch_st != S_IDLE);
  assign w_tick_edge = !r_tick_q && hps_tick_irq;
  assign w_drop_set  = ((w_wr_a || w_wr_b) && w_chg_busy) || (w_wr_s && w_sch_busy);

  assign hps_change_data = {r_state, r_pri, r_pid, r_type};
  assign hps_change_req  = (r_chg_st == C_HOLD);
  assign hps_sched_req   = (r_sch_st == S_HOLD);
  assign irq             = r_irq;

  always_comb begin
    w_chg_nxt     = r_chg_st;
    w_chg_cnt_nxt = r_chg_cnt;
    case (r_chg_st)
      C_IDLE: begin
        if (w_wr_b) begin
          w_chg_nxt     = C_HOLD;
          w_chg_cnt_nxt = HOLD_M1;
        end
      end
      C_HOLD: begin
        if (r_chg_cnt == 8'd0) begin
          // A zero-length guard skips straight back to IDLE
          if (GUARD == 0) begin
            w_chg_nxt = C_IDLE;
          end else begin
            w_chg_nxt     = C_GUARD;
            w_chg_cnt_nxt = GUARD_M1;
          end
        end else begin
          w_chg_cnt_nxt = r_chg_cnt - 8'd1;
        end
      end
      C_GUARD: begin
        if (r_chg_cnt == 8'd0) w_chg_nxt = C_IDLE;
        else                   w_chg_cnt_nxt = r_chg_cnt - 8'd1;
      end
      default: w_chg_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    w_sch_nxt     = r_sch_st;
    w_sch_cnt_nxt = r_sch_cnt;
    w_capture     = 1'b0;
    case (r_sch_st)
      S_IDLE: begin
        if (w_wr_s) begin
          w_sch_nxt     = S_HOLD;
          w_sch_cnt_nxt = HOLD_M1;
        end
      end
      S_HOLD: begin
        if (r_sch_cnt == 8'd0) begin
          w_sch_nxt     = S_WAIT;
          w_sch_cnt_nxt = LAT_M1;
        end else begin
          w_sch_cnt_nxt = r_sch_cnt - 8'd1;
        end
      end
      S_WAIT: begin
        if (r_sch_cnt == 8'd0) begin
          w_sch_nxt = S_IDLE;
          w_capture = 1'b1;
        end else begin
          w_sch_cnt_nxt = r_sch_cnt - 8'd1;
        end
      end
      default: w_sch_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = 32'd0;
    case (avs_address)
      3'd3:    w_rdata = {15'd0, r_next_vld, r_next};
      3'd4:    w_rdata = {27'd0, r_drop, r_ovr, r_pend, w_sch_busy, w_chg_busy};
      3'd6:    w_rdata = r_ticks;
      3'd7:    w_rdata = {31'd0, r_irq_en};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chg_st     <= C_IDLE;
      r_chg_cnt    <= 8'd0;
      r_sch_st     <= S_IDLE;
      r_sch_cnt    <= 8'd0;
      r_type       <= 8'd0;
      r_pri        <= 8'd0;
      r_pid        <= 16'd0;
      r_state      <= 16'd0;
      r_next       <= 16'd0;
      r_next_vld   <= 1'b0;
      r_tick_q     <= 1'b0;
      r_ticks      <= 32'd0;
      r_pend       <= 1'b0;
      r_ovr        <= 1'b0;
      r_drop       <= 1'b0;
      r_irq_en     <= 1'b0;
      r_irq        <= 1'b0;
      avs_readdata <= 32'd0;
    end else begin
      r_chg_st  <= w_chg_nxt;
      r_chg_cnt <= w_chg_cnt_nxt;
      r_sch_st  <= w_sch_nxt;
      r_sch_cnt <= w_sch_cnt_nxt;

      // Staging only moves while the change channel is idle
      if (w_wr_a && !w_chg_busy) begin
        r_type <= avs_writedata[7:0];
        r_pid  <= avs_writedata[23:8];
        r_pri  <= avs_writedata[31:24];
      end
      if (w_wr_b && !w_chg_busy) r_state <= avs_writedata[15:0];

      if (w_capture) begin
        r_next     <= hps_next_process;
        r_next_vld <= 1'b1;
      end else if (w_rd_next) begin
        r_next_vld <= 1'b0;
      end

      r_tick_q <= hps_tick_irq;
      if (w_tick_edge) r_ticks <= r_ticks + 32'd1;

      // A tick edge outranks a same-cycle acknowledge
      if (w_tick_edge)                       r_pend <= 1'b1;
      else if (w_wr_ack && avs_writedata[2]) r_pend <= 1'b0;

      if (w_tick_edge && r_pend)             r_ovr <= 1'b1;
      else if (w_wr_ack && avs_writedata[3]) r_ovr <= 1'b0;

      if (w_drop_set)                        r_drop <= 1'b1;
      else if (w_wr_ack && avs_writedata[4]) r_drop <= 1'b0;

      if (w_wr_ctrl) r_irq_en <= avs_writedata[0];
      r_irq <= r_pend && r_irq_en;

      if (avs_read) avs_readdata <= w_rdata;
    end
  end

endmodule
